// File: rtl/calendar_pkg.sv
// calendar_pkg: field-select codes and calendar arithmetic helpers shared by calendar_core
package calendar_pkg;
    localparam logic [2:0] SEL_NONE  = 3'd0;
    localparam logic [2:0] SEL_SEC   = 3'd1;
    localparam logic [2:0] SEL_MIN   = 3'd2;
    localparam logic [2:0] SEL_HOUR  = 3'd3;
    localparam logic [2:0] SEL_DAY   = 3'd4;
    localparam logic [2:0] SEL_MONTH = 3'd5;
    localparam logic [2:0] SEL_YEAR  = 3'd6;
    localparam logic [2:0] SEL_RSVD  = 3'd7;

    // Year 0 is divisible by 400, so it counts as leap
    function automatic logic is_leap_year(input logic [31:0] y);
        return ((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        return (month == 4'd2) ? (leap ? 5'd29 : 5'd28) :
               (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
    endfunction
endpackage

// File: rtl/calendar_core_tick_prescaler.sv
// tick_prescaler: counts CLK_HZ enabled cycles and flags the terminal cycle
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // tick is combinational so the core can register the field update on the same edge
    always_comb begin
        tick  = en && cnt_q == LAST;
        cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/calendar_core.sv
// calendar_core: time/date counter with prescaled 1 Hz tick, field editing, leap handling and day clamping
module calendar_core
    import calendar_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int YEAR_W     = 12,
    parameter int YEAR_MAX   = 4095,
    parameter int RESET_YEAR = 2000
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              run,
    input  logic [2:0]        sel,
    input  logic              inc,
    input  logic              dec,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              is_leap,
    output logic              tick_1hz,
    output logic              year_wrap
);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RST = YEAR_W'(RESET_YEAR);

    logic [5:0]        sec_q, sec_d, min_q, min_d;
    logic [4:0]        hour_q, hour_d, day_q, day_d, day_raw, dim_cur, dim_new;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              tick_1hz_q, year_wrap_q, year_wrap_d;
    logic              edit, up, dn, tick;
    logic              f_sec, f_min, f_hour, f_day, f_mon, f_year;
    logic              b_sec, b_min, b_hour, b_day, b_mon, b_year;

    assign edit = sel != SEL_NONE && sel != SEL_RSVD;
    assign up   = edit && inc && !dec;
    assign dn   = edit && dec && !inc;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk_50MHz),
        .rst  (rst),
        .en   (run && !edit),
        .clr  (edit),
        .tick (tick)
    );

    // Forward steps come from the tick cascade or an inc edit; the two never coincide
    always_comb begin
        dim_cur     = days_in_month(month_q, is_leap);
        f_sec       = tick || (up && sel == SEL_SEC);
        f_min       = (tick && sec_q == 6'd59) || (up && sel == SEL_MIN);
        f_hour      = (tick && sec_q == 6'd59 && min_q == 6'd59) || (up && sel == SEL_HOUR);
        f_day       = (tick && sec_q == 6'd59 && min_q == 6'd59 && hour_q == 5'd23) || (up && sel == SEL_DAY);
        f_mon       = (f_day && !edit && day_q == dim_cur) || (up && sel == SEL_MONTH);
        f_year      = (f_mon && !edit && month_q == 4'd12) || (up && sel == SEL_YEAR);
        b_sec       = dn && sel == SEL_SEC;
        b_min       = dn && sel == SEL_MIN;
        b_hour      = dn && sel == SEL_HOUR;
        b_day       = dn && sel == SEL_DAY;
        b_mon       = dn && sel == SEL_MONTH;
        b_year      = dn && sel == SEL_YEAR;
        sec_d       = f_sec ? (sec_q == 6'd59 ? 6'd0 : sec_q + 6'd1) : b_sec ? (sec_q == 6'd0 ? 6'd59 : sec_q - 6'd1) : sec_q;
        min_d       = f_min ? (min_q == 6'd59 ? 6'd0 : min_q + 6'd1) : b_min ? (min_q == 6'd0 ? 6'd59 : min_q - 6'd1) : min_q;
        hour_d      = f_hour ? (hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1) : b_hour ? (hour_q == 5'd0 ? 5'd23 : hour_q - 5'd1) : hour_q;
        day_raw     = f_day ? (day_q == dim_cur ? 5'd1 : day_q + 5'd1) : b_day ? (day_q == 5'd1 ? dim_cur : day_q - 5'd1) : day_q;
        month_d     = f_mon ? (month_q == 4'd12 ? 4'd1 : month_q + 4'd1) : b_mon ? (month_q == 4'd1 ? 4'd12 : month_q - 4'd1) : month_q;
        year_d      = f_year ? (year_q == Y_MAX ? '0 : year_q + YEAR_W'(1)) : b_year ? (year_q == '0 ? Y_MAX : year_q - YEAR_W'(1)) : year_q;
        year_wrap_d = f_year && !edit && year_q == Y_MAX;
        dim_new     = days_in_month(month_d, is_leap_year(32'(year_d)));
        day_d       = day_raw > dim_new ? dim_new : day_raw;
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= Y_RST;
            tick_1hz_q  <= 1'b0;
            year_wrap_q <= 1'b0;
        end else begin
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            tick_1hz_q  <= tick;
            year_wrap_q <= year_wrap_d;
        end
    end

    assign sec       = sec_q;
    assign min       = min_q;
    assign hour      = hour_q;
    assign day       = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign is_leap   = is_leap_year(32'(year_q));
    assign tick_1hz  = tick_1hz_q;
    assign year_wrap = year_wrap_q;
endmodule

// File: tb/tb_calendar_core.sv
// tb_calendar_core: scoreboard bench for calendar_core with a 4-cycle tick
module tb_calendar_core;
    localparam int HZ = 4;

    logic        clk = 0, rst = 1, run = 0, inc = 0, dec = 0;
    logic [2:0]  sel = 0;
    logic [5:0]  sec, min;
    logic [4:0]  hour, day;
    logic [3:0]  month;
    logic [11:0] year;
    logic        is_leap, tick_1hz, year_wrap;

    calendar_core #(.CLK_HZ(HZ), .YEAR_W(12), .YEAR_MAX(4095), .RESET_YEAR(2000)) dut (
        .clk_50MHz (clk),
        .rst       (rst),
        .run       (run),
        .sel       (sel),
        .inc       (inc),
        .dec       (dec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .day       (day),
        .month     (month),
        .year      (year),
        .is_leap   (is_leap),
        .tick_1hz  (tick_1hz),
        .year_wrap (year_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    s, mi, h, d, mo, y, lp, tk, wr;
    } snap_t;

    snap_t sb[$];
    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_snap(input string tag, input int s, mi, h, d, mo, y, lp, tk, wr);
        sb.push_back('{tag, s, mi, h, d, mo, y, lp, tk, wr});
    endtask

    task automatic compare_snap();
        snap_t e;
        e = sb.pop_front();
        check({e.tag, ".sec"},   32'(sec),       e.s);
        check({e.tag, ".min"},   32'(min),       e.mi);
        check({e.tag, ".hour"},  32'(hour),      e.h);
        check({e.tag, ".day"},   32'(day),       e.d);
        check({e.tag, ".month"}, 32'(month),     e.mo);
        check({e.tag, ".year"},  32'(year),      e.y);
        check({e.tag, ".leap"},  32'(is_leap),   e.lp);
        check({e.tag, ".tick"},  32'(tick_1hz),  e.tk);
        check({e.tag, ".wrap"},  32'(year_wrap), e.wr);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_1hz && n < 8 * HZ);
    endtask

    task automatic edit(input logic [2:0] f, input int n);
        sel = f;
        inc = n > 0;
        dec = n < 0;
        repeat (n < 0 ? -n : n) @(negedge clk);
        inc = 0;
        dec = 0;
    endtask

    initial begin
        int n, acc;
        rst = 1; run = 1; sel = 0;
        @(negedge clk);
        @(negedge clk);
        expect_snap("reset", 0, 0, 0, 1, 1, 2000, 1, 0, 0);
        compare_snap();
        rst = 0;
        wait_tick(n);
        check("first_tick_latency", n, HZ);
        expect_snap("tick1", 1, 0, 0, 1, 1, 2000, 1, 1, 0);
        compare_snap();
        acc = 0;
        repeat (59) begin
            wait_tick(n);
            acc += n;
        end
        check("sixty_tick_cycles", acc, 59 * HZ);
        expect_snap("min_carry", 0, 1, 0, 1, 1, 2000, 1, 1, 0);
        compare_snap();
        edit(1, -1); edit(2, -2); edit(3, -1); edit(5, -1); edit(4, -1); edit(6, 99);
        expect_snap("set_2099", 59, 59, 23, 31, 12, 2099, 0, 0, 0);
        compare_snap();
        sel = 0;
        wait_tick(n);
        check("exit_edit_latency", n, HZ);
        expect_snap("roll_2100", 0, 0, 0, 1, 1, 2100, 0, 1, 0);
        compare_snap();
        edit(5, 1); edit(6, -76); edit(4, 28);
        expect_snap("set_feb29_2024", 0, 0, 0, 29, 2, 2024, 1, 0, 0);
        compare_snap();
        edit(6, 1);
        expect_snap("clamp_2025", 0, 0, 0, 28, 2, 2025, 0, 0, 0);
        compare_snap();
        edit(1, -1); edit(2, -1); edit(3, -1); edit(6, -25);
        sel = 0;
        wait_tick(n);
        expect_snap("leap_2000", 0, 0, 0, 29, 2, 2000, 1, 1, 0);
        compare_snap();
        edit(4, -1); edit(6, -100); edit(1, -1); edit(2, -1); edit(3, -1);
        sel = 0;
        wait_tick(n);
        expect_snap("noleap_1900", 0, 0, 0, 1, 3, 1900, 0, 1, 0);
        compare_snap();
        edit(1, -1);
        expect_snap("sec_wrap_local", 59, 0, 0, 1, 3, 1900, 0, 0, 0);
        compare_snap();
        inc = 1; dec = 1;
        @(negedge clk);
        inc = 0; dec = 0;
        expect_snap("inc_dec_both", 59, 0, 0, 1, 3, 1900, 0, 0, 0);
        compare_snap();
        run = 0; sel = 0; inc = 1;
        repeat (2 * HZ) @(negedge clk);
        inc = 0;
        expect_snap("count_mode_inc_hold", 59, 0, 0, 1, 3, 1900, 0, 0, 0);
        compare_snap();
        run = 1;
        edit(2, -1); edit(3, -1); edit(5, 9); edit(4, -1); edit(6, -1901);
        expect_snap("set_4095", 59, 59, 23, 31, 12, 4095, 0, 0, 0);
        compare_snap();
        sel = 0;
        wait_tick(n);
        expect_snap("year_wrap", 0, 0, 0, 1, 1, 0, 1, 1, 1);
        compare_snap();
        @(negedge clk);
        check("wrap_pulse_width", 32'(year_wrap), 0);
        check("tick_pulse_width", 32'(tick_1hz), 0);
        edit(6, -1);
        expect_snap("year_dec_wrap", 0, 0, 0, 1, 1, 4095, 0, 0, 0);
        compare_snap();
        sel = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        expect_snap("rst_mid_prescale", 0, 0, 0, 1, 1, 2000, 1, 0, 0);
        compare_snap();
        rst = 0;
        wait_tick(n);
        check("rst_prescale_latency", n, HZ);
        expect_snap("rst_prescale_tick", 1, 0, 0, 1, 1, 2000, 1, 1, 0);
        compare_snap();
        edit(3, 5);
        inc = 1; rst = 1;
        @(negedge clk);
        inc = 0; rst = 0; sel = 0;
        expect_snap("rst_mid_edit", 0, 0, 0, 1, 1, 2000, 1, 0, 0);
        compare_snap();
        wait_tick(n);
        check("rst_edit_latency", n, HZ);
        expect_snap("rst_edit_tick", 1, 0, 0, 1, 1, 2000, 1, 1, 0);
        compare_snap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
